// File: rtl/patch_reducer_mc_pkg.sv
// Shared types and helpers for the patch reducer: FSM encoding and the
// width/popcount functions used to size lane counters and accumulators.
package patch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int MAX_PATCH_SIZE_DFLT = 16;

    function automatic int log2_ceil(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Bits needed to hold a patch size 0..max_size.
    function automatic int patch_sz_w(input int max_size);
        return log2_ceil(max_size + 1);
    endfunction

    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/patch_reducer_mc_if.sv
// Row-sum input stream and patch-result output handshake of the patch reducer.
// The reducer itself is the slave; the row-sum producer/consumer side is the master.
interface patch_reducer_mc_if #(
    parameter int N_LANE         = 2,
    parameter int ROW_SUM_SIZE   = 16,
    parameter int PATCH_SUM_SIZE = 24
);
    logic [N_LANE*ROW_SUM_SIZE-1:0] partial_sum;
    logic [N_LANE-1:0]              partial_sum_valid;
    logic                           partial_sum_rdy;
    logic                           sum_rdy;
    logic                           sum_ack;
    logic [PATCH_SUM_SIZE-1:0]      sum;
    logic                           sum_ovf;

    modport master (
        output partial_sum, partial_sum_valid, sum_ack,
        input  partial_sum_rdy, sum_rdy, sum, sum_ovf
    );

    modport slave (
        input  partial_sum, partial_sum_valid, sum_ack,
        output partial_sum_rdy, sum_rdy, sum, sum_ovf
    );
endinterface

// File: rtl/patch_reducer_mc_lane_adder.sv
// Combinational N-lane zero-extending adder: sums the masked lanes whose index
// is below a count limit and reports how many lanes were consumed.
module lane_adder #(
    parameter int N_LANE       = 2,
    parameter int ROW_SUM_SIZE = 16,
    parameter int OUT_W        = 26,
    parameter int LIM_W        = 5,
    parameter int CNT_W        = 2
) (
    input  logic [N_LANE*ROW_SUM_SIZE-1:0] lanes,
    input  logic [N_LANE-1:0]              lane_mask,
    input  logic [LIM_W-1:0]               limit,
    output logic [OUT_W-1:0]               sum,
    output logic [CNT_W-1:0]               used
);

    always_comb begin
        sum  = '0;
        used = '0;
        // Masks are contiguous from lane 0, so used ends up as min(valid lanes, limit).
        for (int i = 0; i < N_LANE; i++) begin
            if (lane_mask[i] && (i < int'(limit))) begin
                sum  = sum + OUT_W'(lanes[i*ROW_SUM_SIZE +: ROW_SUM_SIZE]);
                used = used + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/patch_reducer_mc.sv
// Patch reducer: accumulates a runtime number of row partial sums into one
// patch sum and hands it off through a one-deep output holding register.
module patch_reducer_mc
    import patch_pkg::*;
#(
    parameter int N_LANE         = 2,
    parameter int ROW_SUM_SIZE   = 16,
    parameter int PATCH_SUM_SIZE = 24,
    parameter int MAX_PATCH_SIZE = MAX_PATCH_SIZE_DFLT,
    parameter int SATURATE       = 1,
    parameter int AUTO_REARM     = 0
) (
    input  logic                                      dram_clk,
    input  logic                                      reset_n,
    input  logic                                      init,
    input  logic [patch_sz_w(MAX_PATCH_SIZE)-1:0]     cfg_patch_size,
    output logic                                      row_err,
    patch_reducer_mc_if.slave                         bus
);

    localparam int SZ_W   = patch_sz_w(MAX_PATCH_SIZE);
    localparam int CNT_W  = log2_ceil(N_LANE + 1);
    localparam int BEAT_W = PATCH_SUM_SIZE + log2_ceil(N_LANE) + 1;
    localparam int FULL_W = BEAT_W + 1;

    // Returns {overflow, result}; the true sum is formed at full width first.
    function automatic logic [PATCH_SUM_SIZE:0] sat_add(
        input logic [PATCH_SUM_SIZE-1:0] a,
        input logic [BEAT_W-1:0]         b
    );
        logic [FULL_W-1:0]         t;
        logic                      ovf;
        logic [PATCH_SUM_SIZE-1:0] r;
        t   = FULL_W'(a) + FULL_W'(b);
        ovf = |t[FULL_W-1:PATCH_SUM_SIZE];
        if (ovf && (SATURATE != 0)) r = '1;
        else                        r = t[PATCH_SUM_SIZE-1:0];
        return {ovf, r};
    endfunction

    state_e                    state_q, state_d;
    logic [PATCH_SUM_SIZE-1:0] acc_q, acc_d;
    logic [SZ_W-1:0]           cnt_q, cnt_d;
    logic [SZ_W-1:0]           size_q, size_d;
    logic                      ovf_q, ovf_d;
    logic                      out_valid_q, out_valid_d;
    logic [PATCH_SUM_SIZE-1:0] sum_q, sum_d;
    logic                      sum_ovf_q, sum_ovf_d;
    logic                      row_err_q, row_err_d;

    logic [N_LANE-1:0]         vld;
    logic                      beat_any;
    logic                      fire;
    logic                      out_free;
    logic [SZ_W-1:0]           rows_left;
    logic [SZ_W-1:0]           cnt_next;
    logic [BEAT_W-1:0]         beat_sum;
    logic [CNT_W-1:0]          used;
    logic [CNT_W-1:0]          k_in;
    logic [PATCH_SUM_SIZE:0]   add_res;

    assign vld       = bus.partial_sum_valid;
    assign beat_any  = |vld;
    assign fire      = beat_any && (state_q == ST_ACCUM);
    assign out_free  = !out_valid_q || bus.sum_ack;
    assign rows_left = size_q - cnt_q;
    assign cnt_next  = cnt_q + SZ_W'(used);
    assign k_in      = CNT_W'(popcount(32'(vld)));
    assign add_res   = sat_add(acc_q, beat_sum);

    lane_adder #(
        .N_LANE       (N_LANE),
        .ROW_SUM_SIZE (ROW_SUM_SIZE),
        .OUT_W        (BEAT_W),
        .LIM_W        (SZ_W),
        .CNT_W        (CNT_W)
    ) u_lane_adder (
        .lanes     (bus.partial_sum),
        .lane_mask (vld),
        .limit     (rows_left),
        .sum       (beat_sum),
        .used      (used)
    );

    always_ff @(posedge dram_clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = ST_ACCUM;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_ACCUM: if (fire && (cnt_next == size_q)) state_d = ST_FULL;
                ST_FULL:  if (out_free) state_d = (AUTO_REARM != 0) ? ST_ACCUM : ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        sum_ovf_d   = sum_ovf_q;
        row_err_d   = 1'b0;

        if (out_valid_q && bus.sum_ack) out_valid_d = 1'b0;

        if (init) begin
            acc_d  = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            size_d = (cfg_patch_size == '0) ? SZ_W'(1) : cfg_patch_size;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (fire) begin
                        acc_d     = add_res[PATCH_SUM_SIZE-1:0];
                        ovf_d     = ovf_q | add_res[PATCH_SUM_SIZE];
                        cnt_d     = cnt_next;
                        row_err_d = (k_in > used);
                    end
                end
                ST_FULL: begin
                    // A load in the same cycle as an ack keeps out_valid set.
                    if (out_free) begin
                        sum_d       = acc_q;
                        sum_ovf_d   = ovf_q;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if ((state_q == ST_IDLE) && beat_any) row_err_d = 1'b1;
    end

    always_ff @(posedge dram_clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            size_q      <= SZ_W'(1);
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            sum_ovf_q   <= 1'b0;
            row_err_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            sum_ovf_q   <= sum_ovf_d;
            row_err_q   <= row_err_d;
        end
    end

    always_comb begin
        bus.partial_sum_rdy = (state_q == ST_ACCUM);
        bus.sum_rdy         = out_valid_q;
        bus.sum             = sum_q;
        bus.sum_ovf         = sum_ovf_q;
        row_err             = row_err_q;
    end

endmodule

// File: tb/tb_patch_reducer_mc.sv
// Bench for patch_reducer_mc: a saturating instance and a wrapping auto-rearm
// instance, driven one at a time from shared stimulus variables.
module tb_patch_reducer_mc;

    localparam longint MAXV = 65535;

    logic        dram_clk;
    logic        reset_n;
    logic        sel;
    logic        d_init;
    logic [4:0]  d_cfg;
    logic [31:0] d_ps;
    logic [1:0]  d_vld;
    logic        d_ack;
    logic        err_a, err_b;

    int checks;
    int errors;

    patch_reducer_mc_if #(.N_LANE(2), .ROW_SUM_SIZE(16), .PATCH_SUM_SIZE(16)) if_a ();
    patch_reducer_mc_if #(.N_LANE(2), .ROW_SUM_SIZE(16), .PATCH_SUM_SIZE(16)) if_b ();

    logic init_a, init_b;
    assign init_a               = sel ? 1'b0 : d_init;
    assign init_b               = sel ? d_init : 1'b0;
    assign if_a.partial_sum       = sel ? 32'd0 : d_ps;
    assign if_a.partial_sum_valid = sel ? 2'b00 : d_vld;
    assign if_a.sum_ack           = sel ? 1'b0 : d_ack;
    assign if_b.partial_sum       = sel ? d_ps : 32'd0;
    assign if_b.partial_sum_valid = sel ? d_vld : 2'b00;
    assign if_b.sum_ack           = sel ? d_ack : 1'b0;

    logic        o_rdy, o_psr, o_ovf, o_err;
    logic [15:0] o_sum;
    assign o_rdy = sel ? if_b.sum_rdy : if_a.sum_rdy;
    assign o_psr = sel ? if_b.partial_sum_rdy : if_a.partial_sum_rdy;
    assign o_ovf = sel ? if_b.sum_ovf : if_a.sum_ovf;
    assign o_sum = sel ? if_b.sum : if_a.sum;
    assign o_err = sel ? err_b : err_a;

    patch_reducer_mc #(
        .N_LANE(2), .ROW_SUM_SIZE(16), .PATCH_SUM_SIZE(16),
        .MAX_PATCH_SIZE(16), .SATURATE(1), .AUTO_REARM(0)
    ) dut_a (
        .dram_clk(dram_clk), .reset_n(reset_n), .init(init_a),
        .cfg_patch_size(d_cfg), .row_err(err_a), .bus(if_a)
    );

    patch_reducer_mc #(
        .N_LANE(2), .ROW_SUM_SIZE(16), .PATCH_SUM_SIZE(16),
        .MAX_PATCH_SIZE(16), .SATURATE(0), .AUTO_REARM(1)
    ) dut_b (
        .dram_clk(dram_clk), .reset_n(reset_n), .init(init_b),
        .cfg_patch_size(d_cfg), .row_err(err_b), .bus(if_b)
    );

    initial dram_clk = 1'b0;
    always #5 dram_clk = ~dram_clk;

    // Valid bits must be contiguous from lane 0.
    always @(posedge dram_clk) begin
        assert ((d_vld & (d_vld + 2'd1)) == 2'd0) else begin
            errors++;
            $error("FAIL lane_contig observed=%b expected=contiguous", d_vld);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge dram_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_init(input int sz);
        d_init = 1'b1;
        d_cfg  = 5'(sz);
        tick();
        d_init = 1'b0;
    endtask

    task automatic send(input int k, input logic [15:0] v0, input logic [15:0] v1);
        d_vld = (k == 2) ? 2'b11 : 2'b01;
        d_ps  = {v1, v0};
        tick();
        d_vld = 2'b00;
    endtask

    task automatic ack();
        d_ack = 1'b1;
        tick();
        d_ack = 1'b0;
    endtask

    initial begin
        int          sz, rem, k, nuse;
        longint      total, expv;
        logic [15:0] v0, v1;
        logic        excess;

        checks  = 0;
        errors  = 0;
        sel     = 1'b0;
        d_init  = 1'b0;
        d_cfg   = 5'd0;
        d_ps    = 32'd0;
        d_vld   = 2'b00;
        d_ack   = 1'b0;
        reset_n = 1'b0;
        repeat (3) tick();

        chk("rst_sum_rdy", {31'd0, o_rdy}, 32'd0);
        chk("rst_sum", {16'd0, o_sum}, 32'd0);
        chk("rst_ovf", {31'd0, o_ovf}, 32'd0);
        chk("rst_psr", {31'd0, o_psr}, 32'd0);
        chk("rst_row_err", {31'd0, o_err}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Six rows over three two-lane beats.
        do_init(6);
        chk("t1_psr_accum", {31'd0, o_psr}, 32'd1);
        send(2, 16'd1, 16'd2);
        send(2, 16'd3, 16'd4);
        send(2, 16'd5, 16'd6);
        chk("t1_rdy_early", {31'd0, o_rdy}, 32'd0);
        chk("t1_psr_full", {31'd0, o_psr}, 32'd0);
        tick();
        chk("t1_rdy", {31'd0, o_rdy}, 32'd1);
        chk("t1_sum", {16'd0, o_sum}, 32'd21);
        chk("t1_ovf", {31'd0, o_ovf}, 32'd0);
        chk("t1_psr_idle", {31'd0, o_psr}, 32'd0);
        ack();
        chk("t1_rdy_acked", {31'd0, o_rdy}, 32'd0);

        // Beat crossing the patch boundary drops lane 1.
        do_init(3);
        send(2, 16'd10, 16'd20);
        chk("t2_err_quiet", {31'd0, o_err}, 32'd0);
        send(2, 16'd30, 16'd40);
        chk("t2_err_pulse", {31'd0, o_err}, 32'd1);
        tick();
        chk("t2_err_clear", {31'd0, o_err}, 32'd0);
        chk("t2_sum", {16'd0, o_sum}, 32'd60);
        chk("t2_rdy", {31'd0, o_rdy}, 32'd1);
        ack();

        // Size 0 is treated as 1.
        do_init(0);
        send(1, 16'd7, 16'd0);
        tick();
        chk("t3_sum", {16'd0, o_sum}, 32'd7);
        chk("t3_rdy", {31'd0, o_rdy}, 32'd1);
        ack();

        // Saturation.
        do_init(2);
        send(2, 16'hFFFF, 16'h0001);
        tick();
        chk("t4_sat_sum", {16'd0, o_sum}, 32'h0000FFFF);
        chk("t4_sat_ovf", {31'd0, o_ovf}, 32'd1);
        ack();

        // Re-init mid-patch discards the partial rows.
        do_init(6);
        send(1, 16'd100, 16'd0);
        send(1, 16'd100, 16'd0);
        send(1, 16'd100, 16'd0);
        do_init(6);
        send(2, 16'd1, 16'd1);
        send(2, 16'd1, 16'd1);
        send(2, 16'd1, 16'd1);
        tick();
        chk("t5_sum", {16'd0, o_sum}, 32'd6);
        chk("t5_ovf", {31'd0, o_ovf}, 32'd0);
        ack();

        // Beat while idle.
        send(1, 16'd5, 16'd0);
        chk("t6_idle_err", {31'd0, o_err}, 32'd1);
        chk("t6_idle_psr", {31'd0, o_psr}, 32'd0);
        tick();
        chk("t6_idle_err_clr", {31'd0, o_err}, 32'd0);

        // Randomized patches against a sum-of-consumed-rows model.
        for (int p = 0; p < 10; p++) begin
            sz     = $urandom_range(1, 16);
            total  = 0;
            rem    = sz;
            excess = 1'b0;
            do_init(sz);
            while (rem > 0) begin
                if ($urandom_range(0, 3) == 0) tick();
                k    = $urandom_range(1, 2);
                v0   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
                v1   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
                nuse = (k < rem) ? k : rem;
                total += longint'(v0);
                if (nuse == 2) total += longint'(v1);
                excess = (k > rem);
                rem   -= nuse;
                send(k, v0, v1);
                if (rem > 0) chk("rnd_err_mid", {31'd0, o_err}, 32'd0);
            end
            chk("rnd_err_last", {31'd0, o_err}, {31'd0, excess});
            tick();
            expv = (total > MAXV) ? MAXV : total;
            chk("rnd_rdy", {31'd0, o_rdy}, 32'd1);
            chk("rnd_sum", {16'd0, o_sum}, 32'(expv));
            chk("rnd_ovf", {31'd0, o_ovf}, {31'd0, (total > MAXV)});
            ack();
            chk("rnd_rdy_acked", {31'd0, o_rdy}, 32'd0);
        end

        // Wrapping, auto-rearm instance.
        sel = 1'b1;
        #1;
        chk("b_rst_rdy", {31'd0, o_rdy}, 32'd0);
        chk("b_rst_psr", {31'd0, o_psr}, 32'd0);
        do_init(2);
        send(2, 16'hFFFF, 16'h0001);
        tick();
        chk("b_wrap_sum", {16'd0, o_sum}, 32'd0);
        chk("b_wrap_ovf", {31'd0, o_ovf}, 32'd1);
        chk("b_wrap_rdy", {31'd0, o_rdy}, 32'd1);
        chk("b_rearm_psr", {31'd0, o_psr}, 32'd1);
        ack();
        chk("b_wrap_acked", {31'd0, o_rdy}, 32'd0);

        send(2, 16'd5, 16'd6);
        tick();
        chk("b_ar1_sum", {16'd0, o_sum}, 32'd11);
        chk("b_ar1_ovf", {31'd0, o_ovf}, 32'd0);
        chk("b_ar1_psr", {31'd0, o_psr}, 32'd1);
        send(2, 16'd7, 16'd8);
        chk("b_ar2_full_psr", {31'd0, o_psr}, 32'd0);
        tick();
        tick();
        chk("b_ar2_hold_psr", {31'd0, o_psr}, 32'd0);
        chk("b_ar2_hold_rdy", {31'd0, o_rdy}, 32'd1);
        chk("b_ar2_hold_sum", {16'd0, o_sum}, 32'd11);
        ack();
        chk("b_ar2_load_rdy", {31'd0, o_rdy}, 32'd1);
        chk("b_ar2_load_sum", {16'd0, o_sum}, 32'd15);
        chk("b_ar2_psr", {31'd0, o_psr}, 32'd1);
        ack();
        chk("b_ar2_acked", {31'd0, o_rdy}, 32'd0);

        // Asynchronous reset with a result pending.
        send(2, 16'd1, 16'd1);
        tick();
        chk("b_pre_rst_rdy", {31'd0, o_rdy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("b_arst_rdy", {31'd0, o_rdy}, 32'd0);
        chk("b_arst_sum", {16'd0, o_sum}, 32'd0);
        chk("b_arst_psr", {31'd0, o_psr}, 32'd0);
        #1;
        reset_n = 1'b1;
        send(1, 16'd9, 16'd0);
        chk("b_post_rst_err", {31'd0, o_err}, 32'd1);
        chk("b_post_rst_rdy", {31'd0, o_rdy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
